// File: rtl/bcd_seg_scan_driver_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_seg_scan_driver_pkg : shared codes, segment constants and glyph table
// Revision: 1.0
// ---------------------------------------------------------------------------
package bcd_seg_scan_driver_pkg;

  localparam logic [3:0] CODE_OVF = 4'b1010;
  localparam logic [3:0] CODE_OFF = 4'b1011;

  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  // Active-high {g,f,e,d,c,b,a}; entry [0] is the glyph for digit 0.
  localparam logic [9:0][6:0] GLYPH_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic       sign;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic [3:0] d4;
  } disp_data_t;

endpackage
`default_nettype wire

// File: rtl/bcd_seg_scan_driver_bcd_to_seg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_to_seg : combinational 4-bit code to active-high seven-segment glyph
// Revision: 1.0
// ---------------------------------------------------------------------------
module bcd_to_seg
  import bcd_seg_scan_driver_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    if (code_i <= 4'd9) begin
      seg_o = GLYPH_TABLE[code_i];
    end else if (code_i == CODE_OVF) begin
      seg_o = SEG_DASH;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_seg_scan_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_seg_scan_driver : 5-position multiplexed sign + quad-BCD display driver
// Revision: 1.0
// ---------------------------------------------------------------------------
module bcd_seg_scan_driver
  import bcd_seg_scan_driver_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       LOAD,
  input  logic       SIGNAL,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD3,
  input  logic [3:0] BCD4,
  output logic [6:0] SEG,
  output logic [4:0] ANODE,
  output logic       FRAME
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);
  localparam logic [6:0] SEG_IDLE   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [4:0] ANODE_IDLE = (SEG_ACTIVE_LOW != 0) ? 5'h1F : 5'h00;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] blank_q, blank_d;
  disp_data_t    data_q, data_d;
  logic [6:0]    seg_q, seg_d;
  logic [4:0]    anode_q, anode_d;
  logic          frame_q, frame_d;

  logic       tick;
  logic [3:0] cur_code;
  logic       cur_lz;
  logic [6:0] cur_glyph;
  logic [6:0] seg_act;
  logic [4:0] anode_act;
  logic       lz1, lz2, lz3;

  bcd_to_seg u_bcd_to_seg (
    .code_i (cur_code),
    .seg_o  (cur_glyph)
  );

  assign tick = (presc_q == PRESC_MAX);
  assign lz1  = (data_q.d1 == 4'd0);
  assign lz2  = lz1 && (data_q.d2 == 4'd0);
  assign lz3  = lz2 && (data_q.d3 == 4'd0);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
    end
    blank_d = blank_q;
    if (tick) begin
      blank_d = BLANK_LOAD;
    end else if (blank_q != '0) begin
      blank_d = blank_q - BW'(1);
    end
    data_d  = LOAD ? {SIGNAL, BCD1, BCD2, BCD3, BCD4} : data_q;
    frame_d = tick && (idx_q == 3'd4);
  end

  // Digit select and leading-zero blanking for the position shown this cycle.
  always_comb begin
    cur_code = data_q.d4;
    cur_lz   = 1'b0;
    case (idx_q)
      3'd1: begin cur_code = data_q.d1; cur_lz = lz1; end
      3'd2: begin cur_code = data_q.d2; cur_lz = lz2; end
      3'd3: begin cur_code = data_q.d3; cur_lz = lz3; end
      default: begin cur_code = data_q.d4; cur_lz = 1'b0; end
    endcase
  end

  always_comb begin
    seg_act   = SEG_OFF;
    anode_act = 5'd0;
    if (blank_q == '0) begin
      anode_act = 5'd1 << idx_q;
      if (idx_q == 3'd0) begin
        seg_act = (data_q.sign && (data_q.d4 != CODE_OFF)) ? SEG_DASH : SEG_OFF;
      end else begin
        seg_act = cur_lz ? SEG_OFF : cur_glyph;
      end
    end
    seg_d   = (SEG_ACTIVE_LOW != 0) ? ~seg_act : seg_act;
    anode_d = (SEG_ACTIVE_LOW != 0) ? ~anode_act : anode_act;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
      blank_q <= BLANK_LOAD;
      data_q  <= '{sign: 1'b0, d1: CODE_OFF, d2: CODE_OFF, d3: CODE_OFF, d4: CODE_OFF};
      seg_q   <= SEG_IDLE;
      anode_q <= ANODE_IDLE;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      blank_q <= blank_d;
      data_q  <= data_d;
      seg_q   <= seg_d;
      anode_q <= anode_d;
      frame_q <= frame_d;
    end
  end

  assign SEG   = seg_q;
  assign ANODE = anode_q;
  assign FRAME = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seg_scan_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bcd_seg_scan_driver : scoreboard bench, active-high and active-low DUTs
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_bcd_seg_scan_driver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       LOAD = 1'b0;
  logic       SIGNAL = 1'b0;
  logic [3:0] BCD1 = 4'd0, BCD2 = 4'd0, BCD3 = 4'd0, BCD4 = 4'd0;
  logic [6:0] SEG, seg_n;
  logic [4:0] ANODE, anode_n;
  logic       FRAME, frame_n;

  always #5 clock = ~clock;

  bcd_seg_scan_driver #(.CLK_DIV(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(0)) dut (
    .clock(clock), .reset(reset), .LOAD(LOAD), .SIGNAL(SIGNAL),
    .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3), .BCD4(BCD4),
    .SEG(SEG), .ANODE(ANODE), .FRAME(FRAME)
  );

  bcd_seg_scan_driver #(.CLK_DIV(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1)) dut_n (
    .clock(clock), .reset(reset), .LOAD(LOAD), .SIGNAL(SIGNAL),
    .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3), .BCD4(BCD4),
    .SEG(seg_n), .ANODE(anode_n), .FRAME(frame_n)
  );

  typedef struct packed {
    logic [4:0] anode;
    logic [6:0] seg;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_frame(input logic [6:0] s0, s1, s2, s3, s4);
    q.push_back('{anode: 5'b00001, seg: s0});
    q.push_back('{anode: 5'b00010, seg: s1});
    q.push_back('{anode: 5'b00100, seg: s2});
    q.push_back('{anode: 5'b01000, seg: s3});
    q.push_back('{anode: 5'b10000, seg: s4});
  endtask

  // Monitor: pops one expectation at every onset of an active position.
  int         cyc = 0;
  int         last_frame = 0;
  bit         frame_valid = 0;
  bit         measuring = 0;
  int         run_len = 0;
  logic [4:0] cur_anode = 5'd0;
  logic [4:0] prev_anode = 5'd0;
  exp_t       e;

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      measuring   = 0;
      frame_valid = 0;
    end else begin
      if (measuring) begin
        if (ANODE == cur_anode) run_len++;
        else begin
          check("active_run_len", 8'(run_len), 8'd3);
          measuring = 0;
        end
      end
      if (ANODE != 5'd0 && ANODE != prev_anode && q.size() > 0) begin
        e = q.pop_front();
        check("anode", {3'd0, ANODE}, {3'd0, e.anode});
        check("seg", {1'b0, SEG}, {1'b0, e.seg});
        check("anode_n", {3'd0, anode_n}, {3'd0, ~e.anode});
        check("seg_n", {1'b0, seg_n}, {1'b0, ~e.seg});
        measuring = 1;
        cur_anode = ANODE;
        run_len   = 1;
      end
      if (FRAME) begin
        if (frame_valid) check("frame_period", 8'(cyc - last_frame), 8'd20);
        last_frame  = cyc;
        frame_valid = 1;
      end
    end
    prev_anode = ANODE;
  end

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", 8'(q.size() != 0), 8'd0);
    q.delete();
    repeat (5) @(negedge clock);
  endtask

  task automatic wait_frame();
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if (FRAME) seen = 1;
    end
    check("frame_timeout", 8'(seen), 8'd1);
  endtask

  task automatic run_frame(input logic sg, input logic [3:0] b1, b2, b3, b4,
                           input logic [6:0] s0, s1, s2, s3, s4, input bit on_tick);
    wait_drain();
    wait_frame();
    if (on_tick) repeat (19) @(negedge clock);
    LOAD = 1'b1; SIGNAL = sg; BCD1 = b1; BCD2 = b2; BCD3 = b3; BCD4 = b4;
    @(negedge clock);
    LOAD = 1'b0;
    push_frame(s0, s1, s2, s3, s4);
  endtask

  initial begin
    logic [4:0] pa;
    bit         found;
    @(negedge clock);
    check("rst_seg", {1'b0, SEG}, 8'h00);
    check("rst_anode", {3'd0, ANODE}, 8'h00);
    @(negedge clock);
    check("rst_frame", {7'd0, FRAME}, 8'h00);
    check("rst_seg_n", {1'b0, seg_n}, 8'h7F);
    check("rst_anode_n", {3'd0, anode_n}, 8'h1F);
    check("rst_frame_n", {7'd0, frame_n}, 8'h00);
    push_frame(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
    reset = 1'b0;

    run_frame(1'b1, 4'd0, 4'd1, 4'd2, 4'd3, 7'h40, 7'h00, 7'h06, 7'h5B, 7'h4F, 0);
    run_frame(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F, 0);
    run_frame(1'b1, 4'hA, 4'hA, 4'hA, 4'hA, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 0);
    run_frame(1'b0, 4'hB, 4'hB, 4'hB, 4'hB, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 0);
    run_frame(1'b1, 4'hB, 4'hB, 4'hB, 4'hB, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 0);
    run_frame(1'b0, 4'd0, 4'd0, 4'd5, 4'd0, 7'h00, 7'h00, 7'h00, 7'h6D, 7'h3F, 1);
    run_frame(1'b1, 4'd1, 4'd0, 4'd0, 4'd0, 7'h40, 7'h06, 7'h3F, 7'h3F, 7'h3F, 1);
    run_frame(1'b1, 4'hC, 4'hD, 4'hE, 4'hF, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 0);
    wait_drain();

    // Reset on the first displayed cycle of position 3 (index still 3).
    found = 0;
    pa = ANODE;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clock);
      if (ANODE == 5'b01000 && pa != 5'b01000) found = 1;
      pa = ANODE;
    end
    check("pos3_timeout", 8'(found), 8'd1);
    reset = 1'b1;
    push_frame(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
    @(negedge clock);
    check("midrst_anode", {3'd0, ANODE}, 8'h00);
    check("midrst_seg", {1'b0, SEG}, 8'h00);
    check("midrst_frame", {7'd0, FRAME}, 8'h00);
    check("midrst_anode_n", {3'd0, anode_n}, 8'h1F);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_blank", {3'd0, ANODE}, 8'h00);
    @(negedge clock);
    check("post_rst_pos0", {3'd0, ANODE}, 8'h01);
    repeat (4) @(negedge clock);
    check("post_rst_pos1", {3'd0, ANODE}, 8'h02);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/bcd_seg_scan_driver.md
Name: bcd_seg_scan_driver

Overview:
- Downstream stage of the quad-BCD converter. Captures sign plus four BCD digits (BCD1 = most significant) on a load strobe.
- Drives a 5-position, time-multiplexed seven-segment display: position 0 is the sign, positions 1..4 are BCD1..BCD4.
- Handles leading-zero blanking, the converter's overflow code (4'b1010) and disabled code (4'b1011).
- Inserts anti-ghosting blank cycles between digit switches.

Parameters:
- CLK_DIV, 50000: clock cycles per display position (refresh tick period); legal range is 2 or more.
- BLANK_CYCLES, 2: cycles with all anodes inactive after each position change; must be less than CLK_DIV.
- SEG_ACTIVE_LOW, 1: 1 means SEG and ANODE are driven active-low; 0 means active-high.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- LOAD  in  1  capture strobe for SIGNAL and BCD1..BCD4
- SIGNAL  in  1  sign of the value (1 = negative)
- BCD1  in  4  most significant digit or code
- BCD2  in  4  digit or code
- BCD3  in  4  digit or code
- BCD4  in  4  least significant digit or code
- SEG  out  7  segments {g,f,e,d,c,b,a}; polarity set by SEG_ACTIVE_LOW
- ANODE  out  5  one-hot position select; bit0 = sign, bit4 = BCD4; polarity set by SEG_ACTIVE_LOW
- FRAME  out  1  one-cycle pulse when the scan wraps from position 4 to position 0

Behaviour:
- Reset is synchronous and active-high, on one clock. In the reset cycle and after it:
  - prescaler = 0, position index = 0, blank counter = BLANK_CYCLES;
  - latched digits = 4'b1011, latched sign = 0;
  - SEG all off, ANODE all inactive, FRAME = 0.
- Capture:
  - When LOAD=1 at a rising edge, SIGNAL and BCD1..4 are registered.
  - The new values are visible on SEG no earlier than the next cycle in which their position is shown.
  - LOAD does not disturb the prescaler, index or blank counter.
  - LOAD held high captures every cycle.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick = (prescaler == CLK_DIV-1).
- Position index:
  - On tick, index advances 0→1→2→3→4→0 and the blank counter reloads to BLANK_CYCLES.
  - When tick occurs with index==4, FRAME pulses high for exactly one cycle, in the same cycle the index becomes 0.
- Blank counter:
  - Decrements each cycle while nonzero.
  - While nonzero, ANODE is all inactive and SEG is all off.
- Outputs are registered: SEG and ANODE reflect the index and blank-counter state of the previous cycle, i.e. one cycle of latency.
- Per-digit decode, positions 1..4:
  - 0..9: standard seven-segment glyphs.
  - 4'b1010 (overflow): dash, segment g only.
  - 4'b1011 and 4'b1100..4'b1111: all off.
- Leading-zero blanking:
  - BCDk (k = 1..3) is blanked when it equals 0 and every more significant latched digit also equals 0.
  - BCD4 is never blanked, so value 0 shows "0".
  - Blanking applies only to the value 0, never to codes 1010 or 1011.
- Sign position: shows dash (g only) when the latched sign is 1 and BCD4 is not 4'b1011; otherwise all off.
- Polarity: with SEG_ACTIVE_LOW=1, "on" = 0 and "inactive" = 1, for both SEG and ANODE.
- Simultaneous LOAD and tick: both take effect. The newly selected position uses the newly latched data.
- Reset mid-scan: everything returns to reset values in the next cycle. No partial frame is completed and FRAME does not pulse.

Decomposition:
- Shared package holds:
  - code constants CODE_OVF=4'b1010 and CODE_OFF=4'b1011;
  - segment constants SEG_DASH=7'b1000000 and SEG_OFF=7'b0000000;
  - the digit glyph table for 0..9 (active-high, {g..a}).
- One sub-module, bcd_to_seg: purely combinational 4-bit code to active-high 7-bit glyph. Polarity inversion and blanking stay in the top level.

Test Plan (CLK_DIV=4, BLANK_CYCLES=1, SEG_ACTIVE_LOW=0):
- Reset held 2 cycles, then released → SEG=0, ANODE=0, FRAME=0 during reset. The first position change occurs 4 cycles after reset is released.
- LOAD with SIGNAL=1, BCDs 0,1,2,3 → over one frame:
  - sign shows 7'b1000000, BCD1 blanked, BCD2..4 show glyphs 1, 2, 3;
  - each position is active for 3 cycles after 1 blank cycle;
  - FRAME pulses once every 20 cycles.
- LOAD with SIGNAL=0, all BCDs 0 → only position 4 shows glyph 0 (7'b0111111); positions 0..3 are all off.
- LOAD with all BCDs 4'b1010 and SIGNAL=1 → all five positions show 7'b1000000.
- LOAD with all BCDs 4'b1011 and SIGNAL=0 → SEG=0 for the whole frame while ANODE still scans.
- Assert reset while index==3 → next cycle ANODE=0 and index=0, with no FRAME pulse. SEG_ACTIVE_LOW=1 rerun: all SEG and ANODE values are bitwise inverted.
